// File: rtl/spi_pkg.sv
// Shared state encoding, default sizing and bit-order helpers for the SPI word shifter.
package spi_pkg;

  typedef enum logic [1:0] {LOCKOUT, IDLE, SHIFT, FULL} state_t;

  localparam int MAX_WIDTH     = 64;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_WORDS = 16;

  // Width of a counter running 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] bit_rev(input logic [MAX_WIDTH-1:0] v);
    logic [MAX_WIDTH-1:0] r;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      r[i] = v[MAX_WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Serial datapath: collects pico bits in wire order and serialises the tx word onto poci.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx_shift,
  input  logic             i_pico,
  input  logic             i_tx_load,
  input  logic             i_tx_shift,
  input  logic             i_tx_first,
  input  logic             i_tx_en,
  input  logic [WIDTH-1:0] i_tx_word,
  output logic [WIDTH-1:0] o_rx_word,
  output logic             o_poci
);

  logic [WIDTH-2:0] r_rx_sh;
  logic [WIDTH-1:0] r_tx_sh;
  logic [WIDTH-1:0] w_rx_wire;
  logic [WIDTH-1:0] w_tx_wire;

  // Wire-order view: index WIDTH-1 is always the first bit on the wire.
  assign w_rx_wire = {r_rx_sh, i_pico};

  if (MSB_FIRST) begin : g_msb
    assign w_tx_wire = i_tx_word;
    assign o_rx_word = w_rx_wire;
  end else begin : g_lsb
    assign w_tx_wire = WIDTH'(bit_rev(MAX_WIDTH'(i_tx_word)) >> (MAX_WIDTH - WIDTH));
    assign o_rx_word = WIDTH'(bit_rev(MAX_WIDTH'(w_rx_wire)) >> (MAX_WIDTH - WIDTH));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_sh <= '0;
      r_tx_sh <= '0;
    end else begin
      if (i_rx_shift) begin
        r_rx_sh <= w_rx_wire[WIDTH-2:0];
      end
      // The first bit goes out straight from tx_word, so only the rest is kept.
      if (i_tx_load) begin
        r_tx_sh <= {w_tx_wire[WIDTH-2:0], 1'b0};
      end else if (i_tx_shift) begin
        r_tx_sh <= {r_tx_sh[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    o_poci = 1'b0;
    if (i_tx_en) begin
      o_poci = i_tx_first ? w_tx_wire[WIDTH-1] : r_tx_sh[WIDTH-1];
    end
  end

endmodule

// File: rtl/spi_word_shifter.sv
// Full-duplex SPI word engine: framing FSM, bit/word counters, sticky error flags.
module spi_word_shifter
  import spi_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic                         spi_clk,
  input  logic                         rst,
  input  logic                         csb,
  input  logic                         pico,
  output logic                         poci,
  input  logic [WIDTH-1:0]             tx_word,
  output logic                         tx_ready,
  output logic [WIDTH-1:0]             rx_word,
  output logic                         rx_valid,
  output logic [$clog2(MAX_WORDS)-1:0] rx_index,
  output logic                         overflow,
  output logic                         frame_err
);

  localparam int BIT_CNT_W  = cnt_w(WIDTH);
  localparam int WORD_CNT_W = cnt_w(MAX_WORDS);
  localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(WIDTH - 1);
  localparam logic [WORD_CNT_W-1:0] WORD_LAST = WORD_CNT_W'(MAX_WORDS - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [WORD_CNT_W-1:0] r_word_cnt;
  logic [WIDTH-1:0]      r_rx_word;
  logic [WORD_CNT_W-1:0] r_rx_index;
  logic                  r_rx_valid;
  logic                  r_tx_ready;
  logic                  r_overflow;
  logic                  r_frame_err;

  logic                  w_active;
  logic                  w_bit_first;
  logic                  w_sample;
  logic                  w_tx_load;
  logic                  w_tx_shift;
  logic                  w_complete;
  logic                  w_break;
  logic                  w_over;
  logic [WIDTH-1:0]      w_rx_word;

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      r_state <= LOCKOUT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOCKOUT: if (csb)  w_state_next = IDLE;
      IDLE:    if (!csb) w_state_next = SHIFT;
      SHIFT: begin
        if (csb) begin
          w_state_next = IDLE;
        end else if (w_complete && (r_word_cnt == WORD_LAST)) begin
          w_state_next = FULL;
        end
      end
      FULL:    if (csb)  w_state_next = IDLE;
      default: w_state_next = LOCKOUT;
    endcase
  end

  always_comb begin
    w_active    = (r_state == IDLE) || (r_state == SHIFT);
    w_bit_first = (r_bit_cnt == '0);
    w_sample    = w_active && !csb;
    w_tx_load   = w_sample && w_bit_first;
    w_tx_shift  = w_sample && !w_bit_first;
    w_complete  = (r_state == SHIFT) && !csb && (r_bit_cnt == BIT_LAST);
    w_break     = (r_state == SHIFT) && csb && !w_bit_first;
    w_over      = (r_state == FULL) && !csb;
  end

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_rx_word   <= '0;
      r_rx_index  <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid <= w_complete;
      r_tx_ready <= w_tx_load;
      if (w_complete) begin
        r_rx_word  <= w_rx_word;
        r_rx_index <= r_word_cnt;
      end
      if (csb) begin
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
      end else if (w_sample) begin
        if (w_complete) begin
          r_bit_cnt  <= '0;
          r_word_cnt <= r_word_cnt + 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
      // A partial word is simply abandoned: rx_word keeps the last complete one.
      if (w_break) r_frame_err <= 1'b1;
      if (w_over)  r_overflow  <= 1'b1;
    end
  end

  spi_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .i_clk      (spi_clk),
    .i_rst      (rst),
    .i_rx_shift (w_sample),
    .i_pico     (pico),
    .i_tx_load  (w_tx_load),
    .i_tx_shift (w_tx_shift),
    .i_tx_first (w_bit_first),
    .i_tx_en    (w_active),
    .i_tx_word  (tx_word),
    .o_rx_word  (w_rx_word),
    .o_poci     (poci)
  );

  assign tx_ready  = r_tx_ready;
  assign rx_word   = r_rx_word;
  assign rx_valid  = r_rx_valid;
  assign rx_index  = r_rx_index;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_word_shifter.sv
// Two shifters (MSB-first and LSB-first, 2 words per frame) fed the same wire traffic.
module tb_spi_word_shifter;

  localparam int W = 8;

  logic         spi_clk = 1'b0;
  logic         rst     = 1'b1;
  logic         csb     = 1'b1;
  logic         pico    = 1'b0;
  logic [W-1:0] tx_word = '0;

  logic         poci_a, poci_b;
  logic         tx_ready_a, tx_ready_b;
  logic [W-1:0] rx_word_a, rx_word_b;
  logic         rx_valid_a, rx_valid_b;
  logic [0:0]   rx_index_a, rx_index_b;
  logic         overflow_a, overflow_b;
  logic         frame_err_a, frame_err_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] word;
    int         idx;
    int         cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  spi_word_shifter #(.WIDTH(W), .MSB_FIRST(1'b1), .MAX_WORDS(2)) dut_a (
    .spi_clk(spi_clk), .rst(rst), .csb(csb), .pico(pico), .poci(poci_a),
    .tx_word(tx_word), .tx_ready(tx_ready_a), .rx_word(rx_word_a),
    .rx_valid(rx_valid_a), .rx_index(rx_index_a), .overflow(overflow_a),
    .frame_err(frame_err_a)
  );

  spi_word_shifter #(.WIDTH(W), .MSB_FIRST(1'b0), .MAX_WORDS(2)) dut_b (
    .spi_clk(spi_clk), .rst(rst), .csb(csb), .pico(pico), .poci(poci_b),
    .tx_word(tx_word), .tx_ready(tx_ready_b), .rx_word(rx_word_b),
    .rx_valid(rx_valid_b), .rx_index(rx_index_b), .overflow(overflow_b),
    .frame_err(frame_err_b)
  );

  always #5 spi_clk = ~spi_clk;

  always @(posedge spi_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expectation per rx_valid pulse.
  always @(negedge spi_clk) begin
    exp_t e;
    #2;
    if (rx_valid_a) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_rx_valid", 32'(rx_valid_a), 32'd0);
      end else begin
        e = q_a.pop_front();
        $display("rx a: word=%02h idx=%0d cyc=%0d", rx_word_a, rx_index_a, cyc);
        check("a_rx_word", 32'(rx_word_a), 32'(e.word));
        check("a_rx_index", 32'(rx_index_a), 32'(e.idx));
        check("a_rx_latency", 32'(cyc), 32'(e.cyc));
      end
    end
    if (rx_valid_b) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_rx_valid", 32'(rx_valid_b), 32'd0);
      end else begin
        e = q_b.pop_front();
        $display("rx b: word=%02h idx=%0d cyc=%0d", rx_word_b, rx_index_b, cyc);
        check("b_rx_word", 32'(rx_word_b), 32'(e.word));
        check("b_rx_index", 32'(rx_index_b), 32'(e.idx));
        check("b_rx_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick(input logic r, input logic c, input logic p);
    @(negedge spi_clk);
    rst  = r;
    csb  = c;
    pico = p;
    #1;
  endtask

  // Sends nbits of wire_v (first wire bit = wire_v[7]); checks poci and tx_ready per bit.
  task automatic send_word(input logic [7:0] wire_v, input logic [7:0] tx,
                           input logic [7:0] exp_a, input logic [7:0] exp_b,
                           input int idx, input int nbits, input bit full);
    for (int i = 0; i < nbits; i++) begin
      @(negedge spi_clk);
      if (i == 0) tx_word = tx;
      rst  = 1'b0;
      csb  = 1'b0;
      pico = wire_v[7-i];
      if (i == 7 && !full) begin
        q_a.push_back(exp_t'{word: exp_a, idx: idx, cyc: cyc + 1});
        q_b.push_back(exp_t'{word: exp_b, idx: idx, cyc: cyc + 1});
      end
      #1;
      check($sformatf("a_poci_bit%0d", i), 32'(poci_a), full ? 32'd0 : 32'(tx[7-i]));
      check($sformatf("b_poci_bit%0d", i), 32'(poci_b), full ? 32'd0 : 32'(tx[i]));
      check($sformatf("a_tx_ready_bit%0d", i), 32'(tx_ready_a), 32'(!full && i == 1));
      check($sformatf("b_tx_ready_bit%0d", i), 32'(tx_ready_b), 32'(!full && i == 1));
    end
    $display("word sent: wire=%02h tx=%02h bits=%0d full=%0d", wire_v, tx, nbits, full);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_a_rx_word"},   32'(rx_word_a),   32'd0);
    check({tag, "_b_rx_word"},   32'(rx_word_b),   32'd0);
    check({tag, "_a_rx_valid"},  32'(rx_valid_a),  32'd0);
    check({tag, "_b_rx_valid"},  32'(rx_valid_b),  32'd0);
    check({tag, "_a_rx_index"},  32'(rx_index_a),  32'd0);
    check({tag, "_b_rx_index"},  32'(rx_index_b),  32'd0);
    check({tag, "_a_tx_ready"},  32'(tx_ready_a),  32'd0);
    check({tag, "_b_tx_ready"},  32'(tx_ready_b),  32'd0);
    check({tag, "_a_overflow"},  32'(overflow_a),  32'd0);
    check({tag, "_b_overflow"},  32'(overflow_b),  32'd0);
    check({tag, "_a_frame_err"}, 32'(frame_err_a), 32'd0);
    check({tag, "_b_frame_err"}, 32'(frame_err_b), 32'd0);
    check({tag, "_a_poci"},      32'(poci_a),      32'd0);
    check({tag, "_b_poci"},      32'(poci_b),      32'd0);
  endtask

  initial begin
    // Power-on reset, then one csb-high edge to leave LOCKOUT.
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check_reset("por");
    tick(1'b0, 1'b1, 1'b0);

    // Two-word frame: A5/idx0 then 3C/idx1, transmitting 5A then C3.
    send_word(8'hA5, 8'h5A, 8'hA5, 8'hA5, 0, 8, 1'b0);
    send_word(8'h3C, 8'hC3, 8'h3C, 8'h3C, 1, 8, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("t1_a_frame_err", 32'(frame_err_a), 32'd0);
    check("t1_b_frame_err", 32'(frame_err_b), 32'd0);
    check("t1_a_overflow", 32'(overflow_a), 32'd0);
    check("t1_a_rx_word_held", 32'(rx_word_a), 32'h3C);

    // Word 0 then csb rises after 5 bits of word 1.
    send_word(8'h80, 8'h0F, 8'h80, 8'h01, 0, 8, 1'b0);
    send_word(8'h12, 8'h96, 8'h00, 8'h00, 1, 5, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("t2_a_frame_err", 32'(frame_err_a), 32'd1);
    check("t2_b_frame_err", 32'(frame_err_b), 32'd1);
    check("t2_a_rx_word_held", 32'(rx_word_a), 32'h80);
    check("t2_b_rx_word_held", 32'(rx_word_b), 32'h01);
    check("t2_a_overflow", 32'(overflow_a), 32'd0);

    // New frame restarts at index 0.
    send_word(8'h12, 8'h96, 8'h12, 8'h48, 0, 8, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    // Three words into a two-word frame: third is dropped, overflow set, poci low.
    send_word(8'hC1, 8'h0F, 8'hC1, 8'h83, 0, 8, 1'b0);
    send_word(8'h3C, 8'h5A, 8'h3C, 8'h3C, 1, 8, 1'b0);
    send_word(8'hFF, 8'hAA, 8'h00, 8'h00, 0, 8, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    check("t4_a_overflow", 32'(overflow_a), 32'd1);
    check("t4_b_overflow", 32'(overflow_b), 32'd1);
    check("t4_a_rx_word_held", 32'(rx_word_a), 32'h3C);

    // rst mid-word with csb held low: nothing accepted until csb cycles high.
    send_word(8'hA5, 8'h5A, 8'h00, 8'h00, 0, 3, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check_reset("rst_mid");
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 1'b0, 1'(i % 2));
      check($sformatf("lock1_a_poci_%0d", i), 32'(poci_a), 32'd0);
      check($sformatf("lock1_a_tx_ready_%0d", i), 32'(tx_ready_a), 32'd0);
    end
    tick(1'b0, 1'b1, 1'b0);
    send_word(8'h6B, 8'h0F, 8'h6B, 8'hD6, 0, 8, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    // rst and csb low on the same edge out of IDLE.
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check_reset("rst_csb");
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      check($sformatf("lock2_a_poci_%0d", i), 32'(poci_a), 32'd0);
      check($sformatf("lock2_b_poci_%0d", i), 32'(poci_b), 32'd0);
    end
    tick(1'b0, 1'b1, 1'b0);
    send_word(8'hC1, 8'h96, 8'hC1, 8'h83, 0, 8, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    check("a_pending_rx", 32'(q_a.size()), 32'd0);
    check("b_pending_rx", 32'(q_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
